// File: rtl/selector_pkg.sv
// selector_pkg: shared constants and helper functions for the pipelined one-hot selector.
//   ADDR_W_DEFAULT       default address width
//   ADDR_W_MIN/MAX       legal address-width range (width must also be even)
//   levels()             number of 2-bit decode levels for an address width
//   out_width()          one-hot output width for an address width
//   line_offset()        start bit of a level's line vector in a flat per-level bus
//   addr_w_legal()       elaboration-time legality check for an address width
package selector_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned ADDR_W_MIN     = 2;
  localparam int unsigned ADDR_W_MAX     = 12;

  function automatic int unsigned levels(input int unsigned addr_w);
    return addr_w / 2;
  endfunction

  function automatic int unsigned out_width(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Level k holds 4^k lines; levels 0..k-1 together occupy (4^k - 1) / 3 bits.
  function automatic int unsigned line_offset(input int unsigned level);
    return ((32'd1 << (2 * level)) - 32'd1) / 32'd3;
  endfunction

  function automatic bit addr_w_legal(input int unsigned addr_w);
    return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) && (addr_w % 2 == 0);
  endfunction

endpackage

// File: rtl/selector_stage.sv
// selector_stage: one registered 4-way expansion level of the selector pipeline.
//   clk_i    clock
//   rst_i    asynchronous active-high reset
//   hold_i   1 = keep all registers, 0 = capture the upstream level
//   valid_i  upstream valid          -> valid_o
//   en_i     upstream enable         -> en_o
//   addr_i   upstream address bits; the top 2 bits select among 4 child lines
//   addr_o   remaining address bits, left-aligned (consumed bits shifted out)
//   lines_i  4^(LEVEL-1) parent lines
//   lines_o  4^LEVEL child lines; child p*4+f is set when parent p is set and field == f
module selector_stage
  import selector_pkg::*;
#(
  parameter int unsigned  LEVEL     = 1,
  parameter int unsigned  ADDR_W    = ADDR_W_DEFAULT,
  localparam int unsigned IN_LINES  = 4 ** (LEVEL - 1),
  localparam int unsigned OUT_LINES = 4 ** LEVEL
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hold_i,
  input  logic                 valid_i,
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [IN_LINES-1:0]  lines_i,
  output logic                 valid_o,
  output logic                 en_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [OUT_LINES-1:0] lines_o
);

  logic [1:0]           field;
  logic [OUT_LINES-1:0] lines_d, lines_q;
  logic [ADDR_W-1:0]    addr_d, addr_q;
  logic                 valid_q, en_q;

  always_comb begin
    field   = addr_i[ADDR_W-1 -: 2];
    addr_d  = addr_i << 2;
    lines_d = '0;
    for (int p = 0; p < int'(IN_LINES); p++) begin
      for (int f = 0; f < 4; f++) begin
        lines_d[p*4 + f] = lines_i[p] && (field == 2'(f));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      lines_q <= '0;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      en_q    <= en_i;
      addr_q  <= addr_d;
      lines_q <= lines_d;
    end
  end

  assign valid_o = valid_q;
  assign en_o    = en_q;
  assign addr_o  = addr_q;
  assign lines_o = lines_q;

endmodule

// File: rtl/selector_pipe.sv
// selector_pipe: pipelined binary-to-one-hot decoder, 2 address bits per level.
//   clk         clock
//   rst         asynchronous active-high reset
//   in_valid    request present
//   in_ready    request accepted when in_valid && in_ready (combinational from out_ready)
//   in_addr     binary address
//   in_en       0 yields an all-zero result for the request
//   out_valid   result present, LEVELS cycles after acceptance
//   out_ready   consumer accepts the result
//   out_onehot  decoded result, bit [in_addr] set when enabled
module selector_pipe
  import selector_pkg::*;
#(
  parameter int unsigned  ADDR_W = ADDR_W_DEFAULT,
  localparam int unsigned LEVELS = levels(ADDR_W),
  localparam int unsigned OUT_W  = out_width(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_onehot
);

  if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
    $error("selector_pipe: ADDR_W must be even and within the legal range");
  end

  localparam int unsigned LINES_TOTAL = line_offset(LEVELS + 1);

  // Index 0 of each bus is the request input; index k is the output of level k.
  logic [LINES_TOTAL-1:0]      lines_bus;
  logic [LEVELS:0]             valid_bus;
  logic [LEVELS:0]             en_bus;
  logic [LEVELS:0][ADDR_W-1:0] addr_bus;
  logic                        advance;

  // Whole pipeline moves as one; bubbles are kept, so throughput is 1/cycle when drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_bus[0] = in_valid;
  assign en_bus[0]    = in_en;
  assign addr_bus[0]  = in_addr;
  // Root line: bubbles and disabled requests carry all-zero lines.
  assign lines_bus[0] = in_valid && in_en;

  for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_level
    selector_stage #(
      .LEVEL  (k),
      .ADDR_W (ADDR_W)
    ) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .hold_i  (!advance),
      .valid_i (valid_bus[k-1]),
      .en_i    (en_bus[k-1]),
      .addr_i  (addr_bus[k-1]),
      .lines_i (lines_bus[line_offset(k-1) +: 4**(k-1)]),
      .valid_o (valid_bus[k]),
      .en_o    (en_bus[k]),
      .addr_o  (addr_bus[k]),
      .lines_o (lines_bus[line_offset(k) +: 4**k])
    );
  end

  assign out_valid  = valid_bus[LEVELS];
  // Lines are already zero when disabled; the en gate makes that explicit at the boundary.
  assign out_onehot = lines_bus[line_offset(LEVELS) +: OUT_W] & {OUT_W{en_bus[LEVELS]}};

  // Every address bit has been consumed by the final level.
  always_comb begin
    if (out_valid) begin
      assert (addr_bus[LEVELS] == '0);
    end
  end

endmodule

// File: tb/tb_selector_pipe.sv
module tb_selector_pipe;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_en     = 1'b1;
  logic        out_ready = 1'b0;
  logic [11:0] r         = '0;

  always #5 clk = ~clk;

  logic          rdy8, ov8, rdy2, ov2, rdy12, ov12;
  logic [255:0]  oh8;
  logic [3:0]    oh2;
  logic [4095:0] oh12;

  selector_pipe #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_addr(r[7:0]),
    .in_en(in_en), .out_valid(ov8), .out_ready(out_ready), .out_onehot(oh8)
  );
  selector_pipe #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_addr(r[1:0]),
    .in_en(in_en), .out_valid(ov2), .out_ready(1'b1), .out_onehot(oh2)
  );
  selector_pipe #(.ADDR_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy12), .in_addr(r),
    .in_en(in_en), .out_valid(ov12), .out_ready(1'b1), .out_onehot(oh12)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [4095:0] v);
    for (int i = 0; i < 4096; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic chk_vec(input string name, input logic [4095:0] got, input logic [4095:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got index %0d (%0d bits set), expected index %0d (%0d bits set)",
               name, idx_of(got), $countones(got), idx_of(exp), $countones(exp));
    end
  endtask

  // Reference for the 8-bit instance: queue of LEVELS result slots, slot 0 is the output.
  // A slot is (valid, address, enable); the whole queue moves only when the output drains.
  logic       mv[4];
  logic       me[4];
  logic [7:0] ma[4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] <= 1'b0; me[i] <= 1'b0; ma[i] <= '0;
      end
    end else if (!mv[0] || out_ready) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] <= mv[i+1]; me[i] <= me[i+1]; ma[i] <= ma[i+1];
      end
      mv[3] <= in_valid; me[3] <= in_en; ma[3] <= r[7:0];
    end
  end

  // The 2- and 12-bit instances never stall, so each output is the input from exactly
  // LEVELS cycles earlier: h[0] is one cycle old, h[5] six cycles old.
  logic        h_v[6];
  logic        h_e[6];
  logic [11:0] h_a[6];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        h_v[i] <= 1'b0; h_e[i] <= 1'b0; h_a[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 6; i++) begin
        h_v[i] <= h_v[i-1]; h_e[i] <= h_e[i-1]; h_a[i] <= h_a[i-1];
      end
      h_v[0] <= in_valid; h_e[0] <= in_en; h_a[0] <= r;
    end
  end

  int       n12_valid = 0;
  logic [3:0] seen2   = '0;

  always @(negedge clk) begin
    logic [4095:0] e;
    e = '0;
    if (mv[0] && me[0]) e[ma[0]] = 1'b1;
    chk("w8 out_valid", ov8, mv[0]);
    chk("w8 in_ready", rdy8, !mv[0] || out_ready);
    if (mv[0]) chk_vec("w8 out_onehot", oh8, e);

    e = '0;
    if (h_v[0] && h_e[0]) e[h_a[0][1:0]] = 1'b1;
    chk("w2 out_valid", ov2, h_v[0]);
    chk("w2 in_ready", rdy2, 1);
    if (h_v[0]) begin
      chk_vec("w2 out_onehot", oh2, e);
      if (h_e[0]) seen2[idx_of(oh2) & 3] = 1'b1;
    end

    e = '0;
    if (h_v[5] && h_e[5]) e[h_a[5]] = 1'b1;
    chk("w12 out_valid", ov12, h_v[5]);
    chk("w12 in_ready", rdy12, 1);
    if (h_v[5]) begin
      chk_vec("w12 out_onehot", oh12, e);
      if (h_e[5]) n12_valid++;
    end
  end

  int got_q[$];
  always @(negedge clk) begin
    if (!rst && ov8 && out_ready) got_q.push_back(idx_of(oh8));
  end

  // Issue one request at posedge+1; expect nothing after 3 edges and the result after 4.
  task automatic req_latency(input logic [7:0] a, input logic en, input string name,
                             input int exp_idx);
    in_valid = 1'b1; r = {4'h0, a}; in_en = en;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({name, " early"}, ov8, 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, " valid"}, ov8, 1);
    chk({name, " index"}, idx_of(oh8), exp_idx);
    chk({name, " bits set"}, $countones(oh8), (exp_idx < 0) ? 0 : 1);
    @(posedge clk); #1;
    in_en = 1'b1;
  endtask

  initial begin
    int       cyc;
    logic     acc, saw_block;
    logic [7:0] stall_addr[5];
    stall_addr[0] = 8'h11; stall_addr[1] = 8'h22; stall_addr[2] = 8'h33;
    stall_addr[3] = 8'h44; stall_addr[4] = 8'h55;

    // Reset state: outputs idle and input ready even with out_ready low.
    repeat (2) @(negedge clk);
    chk("reset out_valid", ov8, 0);
    chk_vec("reset out_onehot", oh8, '0);
    chk("reset in_ready", rdy8, 1);

    // Release reset and issue the first request in the same cycle.
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    req_latency(8'hA5, 1'b1, "addr A5", 165);

    // Back-to-back requests produce results on consecutive cycles.
    in_valid = 1'b1; r = 12'h000;
    @(posedge clk); #1; r = 12'h0FF;
    @(posedge clk); #1; r = 12'h03C;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); chk("b2b 1 valid", ov8, 1); chk("b2b 1 index", idx_of(oh8), 0);
    @(negedge clk); chk("b2b 2 valid", ov8, 1); chk("b2b 2 index", idx_of(oh8), 255);
    @(negedge clk); chk("b2b 3 valid", ov8, 1); chk("b2b 3 index", idx_of(oh8), 60);
    @(posedge clk); #1;

    req_latency(8'h10, 1'b0, "en0", -1);
    repeat (2) @(posedge clk); #1;

    // Stall: consumer blocked for 6 cycles while 5 requests are offered.
    got_q.delete();
    out_ready = 1'b0; cyc = 0; saw_block = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; r = {4'h0, stall_addr[i]};
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = rdy8;
        if (!rdy8) saw_block = 1'b1;
        @(posedge clk); #1;
        cyc++;
        if (cyc == 6) out_ready = 1'b1;
        if (cyc > 40) begin
          chk("stall accept timeout", 1, 0);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("stall in_ready fell", saw_block, 1);
    chk("stall result count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) chk("stall order", got_q[i], stall_addr[i]);

    // Reset with requests in flight: outputs drop at once, nothing stale afterwards.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = 12'h021 + 12'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset valid", ov8, 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset out_valid", ov8, 0);
    chk_vec("async reset out_onehot", oh8, '0);
    chk("async reset in_ready", rdy8, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    req_latency(8'h01, 1'b1, "post-reset", 1);

    // Random traffic with random back-pressure and occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      r         = 12'($urandom);
      in_en     = ($urandom % 8) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 600) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk); #1;

    chk("w2 all addresses seen", seen2, 4'hF);
    chk("w12 >=1000 results", n12_valid >= 1000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_pipe.md
SELECTOR_PIPE -- requirements
Module: selector_pipe

Interface
REQ-001 Parameter ADDR_W, default 8, address width; SHALL be even, range 2..12; other values SHALL fail elaboration.
REQ-002 Derived constant LEVELS = ADDR_W/2, the number of 2-bit decode levels; OUT_W = 2**ADDR_W, the one-hot output width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-007 in_addr  input  ADDR_W  binary address.
REQ-008 in_en  input  1  selector enable; 0 yields an all-zero result for that request.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_onehot  output  OUT_W  decoded result; bit [in_addr] set when enabled.

Function
REQ-012 Decode order: level 1 SHALL decode in_addr[ADDR_W-1:ADDR_W-2] into 4 lines; level k SHALL expand each of the 4^(k-1) lines by 4 using the next lower 2 address bits.
REQ-013 Each level SHALL register its 4^k-line vector, its remaining address bits, its en bit and a valid bit.
REQ-014 Latency SHALL be exactly LEVELS cycles from acceptance to out_valid, with no stall.
REQ-015 A line at level k SHALL be 1 only if its parent line is 1 and the 2-bit field selects it; with en=0 all lines at every level SHALL be 0, while valid still propagates.
REQ-016 When out_valid=1, out_onehot SHALL be exactly zero or exactly one-hot; the set bit index SHALL equal the accepted in_addr.
REQ-017 advance = !out_valid || out_ready; all levels SHALL shift together only when advance=1, otherwise all levels SHALL hold.
REQ-018 in_ready SHALL equal advance; the combinational path out_ready -> in_ready is permitted and documented.
REQ-019 Bubbles (valid=0 stages) SHALL be carried as-is and not collapsed; throughput SHALL be one request per cycle while out_ready=1.
REQ-020 out_onehot and out_valid SHALL be stable while out_valid && !out_ready.
REQ-021 Simultaneous accept and output SHALL complete in the same cycle without loss or duplication.
REQ-022 Address wrap: in_addr = OUT_W-1 SHALL set out_onehot[OUT_W-1]; in_addr = 0 SHALL set bit 0.

Reset
REQ-023 rst=1 SHALL asynchronously clear all valid bits, line vectors, address registers and en registers to 0.
REQ-024 During reset: out_valid=0, out_onehot=0, in_ready=1.
REQ-025 Reset mid-operation SHALL discard all in-flight requests; no result from before reset SHALL appear afterwards.
REQ-026 Deassertion of rst SHALL be honoured on the next clk edge; the first request SHALL be acceptable in that cycle.

Structure
REQ-027 Package selector_pkg SHALL hold ADDR_W_DEFAULT, the levels() and out_width() functions, and the legal-range check constants.
REQ-028 Sub-module selector_stage SHALL implement one registered 4-way expansion level, parametrised by level index and ADDR_W, with a hold input driven by !advance.
REQ-029 selector_pipe SHALL instantiate LEVELS selector_stage instances by generate loop; no hand-unrolled instances.

Verification
REQ-030 ADDR_W=8, out_ready=1, single request addr=0xA5, en=1 -> out_valid at cycle +4, out_onehot has only bit 165 set.
REQ-031 Back-to-back addrs 0x00, 0xFF, 0x3C on consecutive cycles -> bits 0, 255, 60 on three consecutive output cycles.
REQ-032 Request addr=0x10 with en=0 -> out_valid=1 at +4, out_onehot=0.
REQ-033 out_ready=0 for 6 cycles while 5 requests are issued -> in_ready falls once out_valid=1; output held stable; on release all 5 results appear in order with none lost or duplicated.
REQ-034 rst pulsed with 3 requests in flight -> out_valid=0 immediately; no stale result after release; new addr=0x01 yields bit 1 at +4.
REQ-035 ADDR_W=2 and ADDR_W=12 -> exhaustive (2) or random 1000-address (12) check of one-hotness and index, with latency 1 and 6 respectively.
